// File: rtl/fc_sched.sv
// ============================================================================
// Module   : fc_sched
// Purpose  : Sequencer for the fully connected classifier. Streams the feature
//            buffer and weight memory through one time-shared signed MAC,
//            emits one score per class, tracks the running argmax and pulses
//            fc_done at the end of the last class.
// Options  : FC_BIAS_EN - adds bias_addr/bias_rdata; each class accumulator
//            starts from the sign-extended bias instead of zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_sched #(
  parameter int N_IN     = 1152,
  parameter int N_OUT    = 10,
  parameter int DATA_W   = 69,
  parameter int WEIGHT_W = 32,
  parameter int ACC_W    = 113
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fc_enable,
  input  logic                            mem_ready,
  output logic                            rd_en,
  output logic [$clog2(N_IN)-1:0]         feat_addr,
  output logic [$clog2(N_IN*N_OUT)-1:0]   wt_addr,
  input  logic [DATA_W-1:0]               feat_rdata,
  input  logic [WEIGHT_W-1:0]             wt_rdata,
  output logic                            prob_valid,
  output logic [3:0]                      prob_idx,
  output logic [ACC_W-1:0]                prob_data,
  output logic [3:0]                      class_out,
  output logic                            fc_done,
  output logic                            busy
`ifdef FC_BIAS_EN
  ,
  output logic [3:0]                      bias_addr,
  input  logic [WEIGHT_W-1:0]             bias_rdata
`endif
);

  localparam int FA_W   = $clog2(N_IN);
  localparam int WA_W   = $clog2(N_IN*N_OUT);
  localparam int PROD_W = DATA_W + WEIGHT_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                   state;
  logic [3:0]               class_cnt;
  logic                     rdata_vld;   // return data from last cycle's accepted read
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  max_score;
  logic [3:0]               best_idx;

  logic signed [PROD_W-1:0] wt_x;
  logic signed [PROD_W-1:0] ft_x;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic                     take_new;
  logic [3:0]               next_best;
  logic                     last_feat;
  logic                     last_class;

  // Full-precision signed product, operands widened so no bits are lost.
  assign wt_x     = {{(PROD_W-WEIGHT_W){wt_rdata[WEIGHT_W-1]}}, wt_rdata};
  assign ft_x     = {{(PROD_W-DATA_W){feat_rdata[DATA_W-1]}}, feat_rdata};
  assign prod     = wt_x * ft_x;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  // Argmax: class 0 seeds the max; later classes win only when strictly greater.
  assign take_new   = (class_cnt == 4'd0) || (acc > max_score);
  assign next_best  = take_new ? class_cnt : best_idx;
  assign last_feat  = (feat_addr == FA_W'(N_IN-1));
  assign last_class = (class_cnt == 4'(N_OUT-1));

  assign prob_data  = acc;
  assign prob_idx   = class_cnt;

`ifdef FC_BIAS_EN
  logic                    bias_pend;
  logic signed [ACC_W-1:0] bias_ext;
  assign bias_addr = class_cnt;
  assign bias_ext  = {{(ACC_W-WEIGHT_W){bias_rdata[WEIGHT_W-1]}}, bias_rdata};
`endif

  // Control FSM, address counters, MAC accumulator and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_en      <= 1'b0;
      feat_addr  <= '0;
      wt_addr    <= '0;
      class_cnt  <= '0;
      rdata_vld  <= 1'b0;
      acc        <= '0;
      max_score  <= '0;
      best_idx   <= '0;
      class_out  <= '0;
      prob_valid <= 1'b0;
      fc_done    <= 1'b0;
      busy       <= 1'b0;
`ifdef FC_BIAS_EN
      bias_pend  <= 1'b0;
`endif
    end else begin
      prob_valid <= 1'b0;
      fc_done    <= 1'b0;
      // rd_en is only high in ISSUE, so this marks next-cycle return data.
      rdata_vld  <= rd_en && mem_ready;
      // Return data is consumed on the valid bit, independent of mem_ready now.
      if (rdata_vld) begin
        acc <= acc + prod_ext;
      end

      case (state)
        IDLE: begin
          if (fc_enable) begin
            state     <= ISSUE;
            rd_en     <= 1'b1;
            busy      <= 1'b1;
            feat_addr <= '0;
            wt_addr   <= '0;
            class_cnt <= '0;
            acc       <= '0;
            max_score <= '0;
            best_idx  <= '0;
            class_out <= '0;
`ifdef FC_BIAS_EN
            bias_pend <= 1'b1;
`endif
          end
        end

        ISSUE: begin
`ifdef FC_BIAS_EN
          // First ISSUE cycle never carries return data, so the load is safe.
          if (bias_pend) begin
            acc       <= bias_ext;
            bias_pend <= 1'b0;
          end
`endif
          if (mem_ready) begin
            feat_addr <= feat_addr + FA_W'(1);
            wt_addr   <= wt_addr + WA_W'(1);
            if (last_feat) begin
              state <= DRAIN;
              rd_en <= 1'b0;
            end
          end
        end

        DRAIN: begin
          state      <= STORE;
          prob_valid <= 1'b1;
        end

        STORE: begin
          acc       <= '0;
          feat_addr <= '0;
          best_idx  <= next_best;
          if (take_new) begin
            max_score <= acc;
          end
          if (last_class) begin
            state     <= DONE;
            fc_done   <= 1'b1;
            class_out <= next_best;
          end else begin
            class_cnt <= class_cnt + 4'd1;
            state     <= ISSUE;
            rd_en     <= 1'b1;
`ifdef FC_BIAS_EN
            bias_pend <= 1'b1;
`endif
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          rd_en <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fc_sched.sv
// ============================================================================
// Module   : tb_fc_sched
// Purpose  : Self-checking bench for fc_sched. Memories are modelled per
//            scenario; a timeline/score model derived from the block's
//            behavioural rules is compared against the DUT every cycle.
// Options  : FC_BIAS_EN - also runs the bias scenario.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fc_sched;

  localparam int N_IN     = 1152;
  localparam int N_OUT    = 10;
  localparam int DATA_W   = 69;
  localparam int WEIGHT_W = 32;
  localparam int ACC_W    = 113;
  localparam int MAXC     = 20000;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                fc_enable = 1'b0;
  logic                mem_ready = 1'b0;
  logic                rd_en;
  logic [10:0]         feat_addr;
  logic [13:0]         wt_addr;
  logic [DATA_W-1:0]   feat_rdata;
  logic [WEIGHT_W-1:0] wt_rdata;
  logic                prob_valid;
  logic [3:0]          prob_idx;
  logic [ACC_W-1:0]    prob_data;
  logic [3:0]          class_out;
  logic                fc_done;
  logic                busy;

  int scen = 1;
  int n_cmp = 0;
  int n_bad = 0;

  bit               exp_rd   [MAXC];
  bit               exp_rdy  [MAXC];
  int               exp_fa   [MAXC];
  int               exp_wa   [MAXC];
  int               store_cls[MAXC];
  logic [ACC_W-1:0] exp_score[N_OUT];
  logic [ACC_W-1:0] obs_score[N_OUT];
  int               exp_best;
  int               obs_done;

`ifdef FC_BIAS_EN
  logic [3:0]          bias_addr;
  logic [WEIGHT_W-1:0] bias_rdata;
  assign bias_rdata = (scen == 6) ? -{28'd0, bias_addr} : '0;
`endif

  fc_sched dut (
    .clk        (clk),
    .rst        (rst),
    .fc_enable  (fc_enable),
    .mem_ready  (mem_ready),
    .rd_en      (rd_en),
    .feat_addr  (feat_addr),
    .wt_addr    (wt_addr),
    .feat_rdata (feat_rdata),
    .wt_rdata   (wt_rdata),
    .prob_valid (prob_valid),
    .prob_idx   (prob_idx),
    .prob_data  (prob_data),
    .class_out  (class_out),
    .fc_done    (fc_done),
    .busy       (busy)
`ifdef FC_BIAS_EN
    ,
    .bias_addr  (bias_addr),
    .bias_rdata (bias_rdata)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] feat_val(input int s);
    case (s)
      2:       return 69'd5;
      4:       return {1'b0, {68{1'b1}}};
      default: return 69'd1;
    endcase
  endfunction

  function automatic logic [WEIGHT_W-1:0] wt_val(input int s, input int a);
    int c;
    c = a / N_IN;
    case (s)
      2:       return (c == 3) ? 32'hFFFF_FFFF : 32'd0;
      4:       return 32'h7FFF_FFFF;
      6:       return 32'd0;
      default: return 32'(c);
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] rnd69();
    logic [95:0] g;
    g = {$urandom(), $urandom(), $urandom()};
    return g[DATA_W-1:0];
  endfunction

  // Exact class score: optional bias plus the signed dot product.
  function automatic logic [ACC_W-1:0] model_score(input int s, input int c);
    logic signed [ACC_W-1:0] a;
    logic signed [ACC_W-1:0] fx;
    logic signed [ACC_W-1:0] wx;
    a = '0;
`ifdef FC_BIAS_EN
    if (s == 6) a = ACC_W'(-c);
`endif
    fx = $signed(feat_val(s));
    for (int i = 0; i < N_IN; i++) begin
      wx = $signed(wt_val(s, c*N_IN + i));
      a  = a + fx * wx;
    end
    return a;
  endfunction

  // Memories: data appears one cycle after an accepted read, garbage otherwise.
  always @(posedge clk) begin
    if (rd_en === 1'b1 && mem_ready === 1'b1) begin
      feat_rdata <= feat_val(scen);
      wt_rdata   <= wt_val(scen, int'(wt_addr));
    end else begin
      feat_rdata <= rnd69();
      wt_rdata   <= $urandom();
    end
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_rd_en"},      rd_en, 0);
    check({tag, "_busy"},       busy, 0);
    check({tag, "_prob_valid"}, prob_valid, 0);
    check({tag, "_fc_done"},    fc_done, 0);
    check({tag, "_class_out"},  class_out, 0);
    check({tag, "_feat_addr"},  feat_addr, 0);
    check({tag, "_wt_addr"},    wt_addr, 0);
    check({tag, "_prob_idx"},   prob_idx, 0);
    check({tag, "_prob_data"},  prob_data, 0);
  endtask

  // One start-to-finish run; rst_at != 0 asserts reset during that cycle.
  task automatic run(input int s, input bit stall, input int rst_at);
    int t, k, a, d;
    scen = s;
    for (int i = 0; i < MAXC; i++) begin
      exp_rd[i] = 1'b0; exp_rdy[i] = 1'b0; exp_fa[i] = 0; exp_wa[i] = 0; store_cls[i] = -1;
    end
    // Expected timeline: ISSUE until N_IN accepts, then DRAIN, STORE.
    t = 1; k = 0;
    for (int c = 0; c < N_OUT; c++) begin
      a = 0;
      while (a < N_IN) begin
        exp_rd[t]  = 1'b1;
        exp_rdy[t] = !(stall && (k % 3 == 2));
        exp_fa[t]  = a;
        exp_wa[t]  = c*N_IN + a;
        if (exp_rdy[t]) a++;
        k++; t++;
      end
      store_cls[t+1] = c;
      t = t + 2;
    end
    d = t;
    for (int c = 0; c < N_OUT; c++) begin
      exp_score[c] = model_score(s, c);
      obs_score[c] = '1;
    end
    exp_best = 0;
    for (int c = 1; c < N_OUT; c++)
      if ($signed(exp_score[c]) > $signed(exp_score[exp_best])) exp_best = c;
    obs_done = -1;

    @(negedge clk);
    fc_enable = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    for (int cyc = 1; cyc <= d + 2; cyc++) begin
      @(negedge clk);
      if (rst_at != 0 && cyc == rst_at + 1) begin
        rst = 1'b0;
        check_idle_zero("post_rst");
        for (int j = 0; j < 20; j++) begin
          @(negedge clk);
          check("post_rst_prob_valid", prob_valid, 0);
          check("post_rst_fc_done",    fc_done, 0);
          check("post_rst_busy",       busy, 0);
        end
        return;
      end
      check("busy",  busy, cyc <= d);
      check("rd_en", rd_en, exp_rd[cyc]);
      if (exp_rd[cyc]) begin
        check("feat_addr", feat_addr, exp_fa[cyc]);
        check("wt_addr",   wt_addr,   exp_wa[cyc]);
      end
      check("prob_valid", prob_valid, store_cls[cyc] >= 0);
      if (store_cls[cyc] >= 0) begin
        check("prob_idx",  prob_idx,  store_cls[cyc]);
        check("prob_data", prob_data, exp_score[store_cls[cyc]]);
      end
      check("fc_done",   fc_done,   cyc == d);
      check("class_out", class_out, (cyc >= d) ? exp_best : 0);
      if (prob_valid === 1'b1 && prob_idx < N_OUT) obs_score[prob_idx] = prob_data;
      if (fc_done === 1'b1) obs_done = cyc;
      fc_enable = (cyc < 6);
      mem_ready = exp_rd[cyc] ? exp_rdy[cyc] : 1'($urandom_range(0, 1));
      rst       = (rst_at != 0 && cyc == rst_at);
    end
  endtask

  logic [ACC_W-1:0] lit;

  // Scenario sequence with literal pins on the model and the DUT.
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;

    run(1, 1'b0, 0);
    check("s1_done_cycle", obs_done, 11541);
    check("s1_score9",     obs_score[9], 10368);
    check("s1_score1",     obs_score[1], 1152);
    check("s1_class_out",  class_out, 9);

    run(2, 1'b0, 0);
    lit = -113'sd5760;
    check("s2_score3",    obs_score[3], lit);
    check("s2_score4",    obs_score[4], 0);
    check("s2_class_out", class_out, 0);

    run(3, 1'b1, 0);
    check("s3_done_cycle", obs_done, 11541 + 5759);
    check("s3_score9",     obs_score[9], 10368);
    check("s3_class_out",  class_out, 9);

    run(4, 1'b0, 0);
    lit = 113'(1152) * ((113'(1) << 68) - 113'(1)) * ((113'(1) << 31) - 113'(1));
    check("s4_score0", obs_score[0], lit);
    check("s4_score9", obs_score[9], lit);

    run(1, 1'b0, 500);
    run(1, 1'b0, 0);
    check("s5_done_cycle", obs_done, 11541);
    check("s5_score9",     obs_score[9], 10368);
    check("s5_class_out",  class_out, 9);

`ifdef FC_BIAS_EN
    run(6, 1'b0, 0);
    lit = -113'sd9;
    check("s6_score9",    obs_score[9], lit);
    check("s6_score0",    obs_score[0], 0);
    check("s6_class_out", class_out, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
